// File: rtl/sdp_alu_pipe_if.sv
// Stream interface for sdp_alu_pipe: input transaction handshake plus result handshake.
interface sdp_alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op1;
  logic [1:0]       op2;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ovf;

  // Producer/consumer side that drives transactions and accepts results.
  modport master (
    output in_valid, op1, op2, a, b, c, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  // Pipeline side.
  modport slave (
    input  in_valid, op1, op2, a, b, c, out_ready,
    output in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/sdp_alu_pipe.sv
// Three-stage add/subtract pipeline computing out = (a op1 b) op2 c with
// valid/ready flow control, optional unsigned saturation and a sticky
// carry/borrow flag per result.
module sdp_alu_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input logic         clk,
  input logic         reset,
  sdp_alu_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_RSB  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  // Returns {flag, result} for f(x, y); result is clamped when saturating.
  function automatic logic [WIDTH:0] f_apply(input op_e op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH:0]   sum;
    logic             flag;
    logic [WIDTH-1:0] res;
    sum  = '0;
    flag = 1'b0;
    res  = x;
    case (op)
      OP_ADD: begin
        sum  = {1'b0, x} + {1'b0, y};
        flag = sum[WIDTH];
        res  = (SATURATE && flag) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        flag = (x < y);
        res  = (SATURATE && flag) ? '0 : (x - y);
      end
      OP_RSB: begin
        flag = (y < x);
        res  = (SATURATE && flag) ? '0 : (y - x);
      end
      default: begin
        flag = 1'b0;
        res  = x;
      end
    endcase
    return {flag, res};
  endfunction

  // Stage 1 registers
  logic             r_v1;
  op_e              r_op1_s1;
  op_e              r_op2_s1;
  logic [WIDTH-1:0] r_a_s1;
  logic [WIDTH-1:0] r_b_s1;
  logic [WIDTH-1:0] r_c_s1;

  // Stage 2 registers
  logic             r_v2;
  logic [WIDTH-1:0] r_m_s2;
  op_e              r_op2_s2;
  logic [WIDTH-1:0] r_c_s2;
  logic             r_f2;

  // Stage 3 registers
  logic             r_v3;
  logic [WIDTH-1:0] r_out;
  logic             r_ovf;

  // Ready chain and stage arithmetic
  logic             w_r1;
  logic             w_r2;
  logic             w_r3;
  logic [WIDTH:0]   w_s2;
  logic [WIDTH:0]   w_s3;

  assign w_r3 = ~r_v3 | bus.out_ready;
  assign w_r2 = ~r_v2 | w_r3;
  assign w_r1 = ~r_v1 | w_r2;

  assign w_s2 = f_apply(r_op1_s1, r_a_s1, r_b_s1);
  assign w_s3 = f_apply(r_op2_s2, r_m_s2, r_c_s2);

  assign bus.in_ready  = w_r1;
  assign bus.out_valid = r_v3;
  assign bus.out       = r_out;
  assign bus.ovf       = r_ovf;

  // Stage 1: capture the incoming transaction when the chain allows it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1     <= 1'b0;
      r_op1_s1 <= OP_ADD;
      r_op2_s1 <= OP_ADD;
      r_a_s1   <= '0;
      r_b_s1   <= '0;
      r_c_s1   <= '0;
    end else if (w_r1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_op1_s1 <= op_e'(bus.op1);
        r_op2_s1 <= op_e'(bus.op2);
        r_a_s1   <= bus.a;
        r_b_s1   <= bus.b;
        r_c_s1   <= bus.c;
      end
    end
  end

  // Stage 2: apply op1 to (a, b) and carry op2/c forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v2     <= 1'b0;
      r_m_s2   <= '0;
      r_op2_s2 <= OP_ADD;
      r_c_s2   <= '0;
      r_f2     <= 1'b0;
    end else if (w_r2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_m_s2   <= w_s2[WIDTH-1:0];
        r_f2     <= w_s2[WIDTH];
        r_op2_s2 <= r_op2_s1;
        r_c_s2   <= r_c_s1;
      end
    end
  end

  // Stage 3: apply op2 to (m, c) and merge both stage flags into ovf.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v3  <= 1'b0;
      r_out <= '0;
      r_ovf <= 1'b0;
    end else if (w_r3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_out <= w_s3[WIDTH-1:0];
        r_ovf <= r_f2 | w_s3[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_sdp_alu_pipe.sv
// Directed bench for sdp_alu_pipe: three instances (8-bit wrap, 8-bit saturate,
// 16-bit wrap) share one stimulus stream and are checked against hand-derived values.
module tb_sdp_alu_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  op1 = 2'b00;
  logic [1:0]  op2 = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] c = '0;

  int comp = 0;
  int errs = 0;

  always #5 clk = ~clk;

  sdp_alu_pipe_if #(.WIDTH(8))  if_w8s0 ();
  sdp_alu_pipe_if #(.WIDTH(8))  if_w8s1 ();
  sdp_alu_pipe_if #(.WIDTH(16)) if_w16  ();

  assign if_w8s0.in_valid  = in_valid;
  assign if_w8s0.out_ready = out_ready;
  assign if_w8s0.op1       = op1;
  assign if_w8s0.op2       = op2;
  assign if_w8s0.a         = a[7:0];
  assign if_w8s0.b         = b[7:0];
  assign if_w8s0.c         = c[7:0];

  assign if_w8s1.in_valid  = in_valid;
  assign if_w8s1.out_ready = out_ready;
  assign if_w8s1.op1       = op1;
  assign if_w8s1.op2       = op2;
  assign if_w8s1.a         = a[7:0];
  assign if_w8s1.b         = b[7:0];
  assign if_w8s1.c         = c[7:0];

  assign if_w16.in_valid   = in_valid;
  assign if_w16.out_ready  = out_ready;
  assign if_w16.op1        = op1;
  assign if_w16.op2        = op2;
  assign if_w16.a          = a;
  assign if_w16.b          = b;
  assign if_w16.c          = c;

  sdp_alu_pipe #(.WIDTH(8),  .SATURATE(1'b0)) u_w8s0 (.clk(clk), .reset(reset), .bus(if_w8s0));
  sdp_alu_pipe #(.WIDTH(8),  .SATURATE(1'b1)) u_w8s1 (.clk(clk), .reset(reset), .bus(if_w8s1));
  sdp_alu_pipe #(.WIDTH(16), .SATURATE(1'b0)) u_w16  (.clk(clk), .reset(reset), .bus(if_w16));

  logic [15:0] o_out [3];
  logic        o_ovf [3];
  logic        o_val [3];
  logic        o_rdy [3];

  assign o_out[0] = {8'd0, if_w8s0.out};
  assign o_out[1] = {8'd0, if_w8s1.out};
  assign o_out[2] = if_w16.out;
  assign o_ovf[0] = if_w8s0.ovf;
  assign o_ovf[1] = if_w8s1.ovf;
  assign o_ovf[2] = if_w16.ovf;
  assign o_val[0] = if_w8s0.out_valid;
  assign o_val[1] = if_w8s1.out_valid;
  assign o_val[2] = if_w16.out_valid;
  assign o_rdy[0] = if_w8s0.in_ready;
  assign o_rdy[1] = if_w8s1.in_ready;
  assign o_rdy[2] = if_w16.in_ready;

  string dn [3] = '{"w8s0", "w8s1", "w16s0"};

  // Single-transaction arithmetic vectors; expected rows: w8s0, w8s1, w16s0.
  logic [1:0]  ar_op1 [5] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
  logic [1:0]  ar_op2 [5] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd0};
  logic [15:0] ar_a   [5] = '{16'd10, 16'd200, 16'd3,  16'd3,  16'd255};
  logic [15:0] ar_b   [5] = '{16'd20, 16'd100, 16'd10, 16'd10, 16'd0};
  logic [15:0] ar_c   [5] = '{16'd5,  16'd0,   16'd9,  16'd9,  16'd1};
  logic [15:0] ar_eo  [3][5] = '{'{16'd35, 16'd44,  16'd254,   16'd7, 16'd0},
                                 '{16'd35, 16'd255, 16'd0,     16'd7, 16'd255},
                                 '{16'd35, 16'd300, 16'd65534, 16'd7, 16'd256}};
  logic        ar_ef  [3][5] = '{'{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
                                 '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
                                 '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};

  // Streamed vectors for the backpressure/reset scenario.
  logic [1:0]  st_op1 [5] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0};
  logic [1:0]  st_op2 [5] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd3};
  logic [15:0] st_a   [5] = '{16'd10, 16'd5, 16'd100, 16'd77, 16'd250};
  logic [15:0] st_b   [5] = '{16'd20, 16'd9, 16'd50,  16'd1,  16'd10};
  logic [15:0] st_c   [5] = '{16'd30, 16'd1, 16'd200, 16'd7,  16'd3};
  logic [15:0] st_eo  [3][5] = '{'{16'd60, 16'd253,   16'd50, 16'd70, 16'd4},
                                 '{16'd60, 16'd1,     16'd50, 16'd70, 16'd255},
                                 '{16'd60, 16'd65533, 16'd50, 16'd70, 16'd260}};
  logic        st_ef  [3][5] = '{'{1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
                                 '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
                                 '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};

  task automatic test_reset();
    #2;
    for (int d = 0; d < 3; d++) begin
      comp++;
      if (o_val[d] !== 1'b0 || o_out[d] !== 16'd0 || o_ovf[d] !== 1'b0) begin
        errs++;
        $display("FAIL por_state %s: valid=%b out=%0d ovf=%b, want 0/0/0", dn[d], o_val[d], o_out[d], o_ovf[d]);
      end
      comp++;
      if (o_rdy[d] !== 1'b1) begin
        errs++;
        $display("FAIL por_in_ready %s: got %b want 1", dn[d], o_rdy[d]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; op1 = 2'd0; op2 = 2'd0; a = 16'd10; b = 16'd20; c = 16'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      comp++;
      if (o_val[d] !== 1'b1 || o_out[d] !== 16'd35) begin
        errs++;
        $display("FAIL pre_reset_load %s: valid=%b out=%0d, want 1/35", dn[d], o_val[d], o_out[d]);
      end
    end
    #3;
    reset = 1'b1;
    in_valid = 1'b1; a = 16'd99; b = 16'd1; c = 16'd1;
    #1;
    for (int d = 0; d < 3; d++) begin
      comp++;
      if (o_val[d] !== 1'b0 || o_out[d] !== 16'd0 || o_ovf[d] !== 1'b0) begin
        errs++;
        $display("FAIL async_reset_state %s: valid=%b out=%0d ovf=%b, want 0/0/0", dn[d], o_val[d], o_out[d], o_ovf[d]);
      end
      comp++;
      if (o_rdy[d] !== 1'b1) begin
        errs++;
        $display("FAIL async_reset_in_ready %s: got %b want 1", dn[d], o_rdy[d]);
      end
    end
    @(posedge clk); #3;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (o_val[d] !== 1'b0) begin
          errs++;
          $display("FAIL reset_no_capture %s cyc%0d: out_valid=%b want 0", dn[d], k, o_val[d]);
        end
      end
    end
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      op1 = ar_op1[k]; op2 = ar_op2[k]; a = ar_a[k]; b = ar_b[k]; c = ar_c[k];
      @(posedge clk); #1;
      in_valid = 1'b0;
      op1 = 2'd3; op2 = 2'd2; a = 16'h00EE; b = 16'h0011; c = 16'h0022;
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (o_val[d] !== 1'b0) begin
          errs++;
          $display("FAIL arith%0d_lat_n %s: out_valid=%b want 0", k, dn[d], o_val[d]);
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (o_val[d] !== 1'b0) begin
          errs++;
          $display("FAIL arith%0d_lat_n1 %s: out_valid=%b want 0", k, dn[d], o_val[d]);
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (o_val[d] !== 1'b1 || o_out[d] !== ar_eo[d][k] || o_ovf[d] !== ar_ef[d][k]) begin
          errs++;
          $display("FAIL arith%0d_result %s: valid=%b out=%0d ovf=%b, want 1/%0d/%b",
                   k, dn[d], o_val[d], o_out[d], o_ovf[d], ar_eo[d][k], ar_ef[d][k]);
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (o_val[d] !== 1'b0 || o_out[d] !== ar_eo[d][k] || o_ovf[d] !== ar_ef[d][k]) begin
          errs++;
          $display("FAIL arith%0d_retain %s: valid=%b out=%0d ovf=%b, want 0/%0d/%b",
                   k, dn[d], o_val[d], o_out[d], o_ovf[d], ar_eo[d][k], ar_ef[d][k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    op1 = 2'd0; op2 = 2'd0; b = 16'd0; c = 16'd0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      a = 16'(k);
      #3;
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (o_rdy[d] !== 1'b1) begin
          errs++;
          $display("FAIL fill_in_ready %s tx%0d: got %b want 1", dn[d], k, o_rdy[d]);
        end
      end
      @(posedge clk); #1;
    end
    a = 16'd4;
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (o_rdy[d] !== 1'b0 || o_val[d] !== 1'b1 || o_out[d] !== 16'd1) begin
          errs++;
          $display("FAIL stall %s cyc%0d: in_ready=%b valid=%b out=%0d, want 0/1/1",
                   dn[d], k, o_rdy[d], o_val[d], o_out[d]);
        end
      end
      if (k < 2) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      comp++;
      if (o_rdy[d] !== 1'b1) begin
        errs++;
        $display("FAIL release_in_ready %s: got %b want 1", dn[d], o_rdy[d]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'd9;
    for (int k = 2; k <= 5; k++) begin
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (k <= 4) begin
          if (o_val[d] !== 1'b1 || o_out[d] !== 16'(k) || o_ovf[d] !== 1'b0) begin
            errs++;
            $display("FAIL drain %s: valid=%b out=%0d ovf=%b, want 1/%0d/0", dn[d], o_val[d], o_out[d], o_ovf[d], k);
          end
        end else begin
          if (o_val[d] !== 1'b0 || o_out[d] !== 16'd4) begin
            errs++;
            $display("FAIL drain_end %s: valid=%b out=%0d, want 0/4", dn[d], o_val[d], o_out[d]);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream_reset();
    logic [15:0] gaps;
    int sent;
    int dcnt [3];
    gaps = 16'b1011_0110_1101_0111;
    sent = 0;
    dcnt = '{0, 0, 0};
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent == 5 && dcnt[0] == 5 && dcnt[1] == 5 && dcnt[2] == 5) break;
      out_ready = (cyc % 2 == 0);
      if (sent < 5 && gaps[cyc % 16]) begin
        in_valid = 1'b1;
        op1 = st_op1[sent]; op2 = st_op2[sent]; a = st_a[sent]; b = st_b[sent]; c = st_c[sent];
      end else begin
        in_valid = 1'b0;
        op1 = 2'd1; op2 = 2'd1; a = 16'h00AA; b = 16'h00BB; c = 16'h00CC;
      end
      @(negedge clk);
      if (in_valid && o_rdy[0]) sent++;
      for (int d = 0; d < 3; d++) begin
        if (o_val[d] && out_ready) begin
          comp++;
          if (dcnt[d] >= 5) begin
            errs++;
            $display("FAIL stream_extra %s: unexpected result out=%0d", dn[d], o_out[d]);
          end else if (o_out[d] !== st_eo[d][dcnt[d]] || o_ovf[d] !== st_ef[d][dcnt[d]]) begin
            errs++;
            $display("FAIL stream_result %s #%0d: out=%0d ovf=%b, want %0d/%b",
                     dn[d], dcnt[d], o_out[d], o_ovf[d], st_eo[d][dcnt[d]], st_ef[d][dcnt[d]]);
          end
          dcnt[d]++;
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      comp++;
      if (dcnt[d] != 5) begin
        errs++;
        $display("FAIL stream_count %s: delivered %0d want 5", dn[d], dcnt[d]);
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b1; op1 = 2'd0; op2 = 2'd0; a = 16'h0011; b = 16'd1; c = 16'd1;
    @(posedge clk); #1;
    a = 16'h0022;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      comp++;
      if (o_val[d] !== 1'b1 || o_out[d] !== 16'h0013) begin
        errs++;
        $display("FAIL inflight_head %s: valid=%b out=%0d, want 1/19", dn[d], o_val[d], o_out[d]);
      end
    end
    #3;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      comp++;
      if (o_val[d] !== 1'b0 || o_out[d] !== 16'd0) begin
        errs++;
        $display("FAIL inflight_reset %s: valid=%b out=%0d, want 0/0", dn[d], o_val[d], o_out[d]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        comp++;
        if (o_val[d] !== 1'b0) begin
          errs++;
          $display("FAIL discarded_delivered %s cyc%0d: out_valid=%b out=%0d", dn[d], k, o_val[d], o_out[d]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_stream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", comp);
    $fatal(1, "watchdog expired");
  end

endmodule
